// File: rtl/ulpi_if.sv
// ULPI link/PHY signal bundle. master is the link side, slave is the PHY side.
interface ulpi_if;
  logic       dir;
  logic       nxt;
  logic       stp;
  wire  [7:0] data;

  modport master (
    input  dir,
    input  nxt,
    output stp,
    inout  data
  );

  modport slave (
    output dir,
    output nxt,
    input  stp,
    inout  data
  );
endinterface

// File: rtl/ulpi_link.sv
// ULPI link-side bus controller: RX CMD / data capture and a single-byte TX CMD
// state machine with abort-and-resend when the PHY grabs the bus.
module ulpi_link (
  input  logic          clk,
  input  logic          reset,
  output logic [7:0]    sys_data,
  output logic          sys_data_valid,
  output logic [7:0]    sys_rx_cmd,
  input  logic [7:0]    sys_cmd,
  input  logic          sys_cmd_strobe,
  output logic          sys_cmd_busy,
  ulpi_if.master        ulpi
);

  typedef enum logic [1:0] {StIdle, StCmd, StStop, StWait} state_e;

  state_e     state_q;
  logic       dir_q;
  logic       stp_q;
  logic [7:0] tx_q;
  logic [7:0] cmd_q;
  logic       drive_en;

  // Gated on the live dir so the link lets go in the same cycle the PHY claims the bus.
  assign drive_en  = !ulpi.dir && !dir_q;
  assign ulpi.data = drive_en ? tx_q : 8'hzz;
  assign ulpi.stp  = stp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      dir_q          <= 1'b0;
      stp_q          <= 1'b0;
      tx_q           <= 8'h00;
      cmd_q          <= 8'h00;
      sys_data       <= 8'h00;
      sys_data_valid <= 1'b0;
      sys_rx_cmd     <= 8'h00;
      sys_cmd_busy   <= 1'b0;
    end else begin
      dir_q          <= ulpi.dir;
      sys_data_valid <= 1'b0;

      // Only capture once the PHY has owned the bus for a full cycle.
      if (ulpi.dir && dir_q) begin
        if (ulpi.nxt) begin
          sys_data       <= ulpi.data;
          sys_data_valid <= 1'b1;
        end else begin
          sys_rx_cmd <= ulpi.data;
        end
      end

      case (state_q)
        StIdle: begin
          stp_q <= 1'b0;
          tx_q  <= 8'h00;
          if (sys_cmd_strobe) begin
            cmd_q        <= sys_cmd;
            tx_q         <= sys_cmd;
            sys_cmd_busy <= 1'b1;
            state_q      <= StCmd;
          end
        end
        StCmd: begin
          if (ulpi.dir) begin
            tx_q    <= cmd_q;
            state_q <= StWait;
          end else if (ulpi.nxt && !dir_q) begin
            tx_q    <= 8'h00;
            stp_q   <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          stp_q <= 1'b0;
          if (ulpi.dir) begin
            tx_q    <= cmd_q;
            state_q <= StWait;
          end else begin
            sys_cmd_busy <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StWait: begin
          // Preload the command so it goes out as soon as the bus comes back.
          stp_q <= 1'b0;
          tx_q  <= cmd_q;
          if (!ulpi.dir && !dir_q) begin
            state_q <= StCmd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_link.sv
// Directed bench for ulpi_link: reset, RX CMD, RX data, TX, abort, reset cases.
module tb_ulpi_link;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sys_data;
  logic       sys_data_valid;
  logic [7:0] sys_rx_cmd;
  logic [7:0] sys_cmd;
  logic       sys_cmd_strobe;
  logic       sys_cmd_busy;

  logic       phy_dir;
  logic       phy_nxt;
  logic       phy_oe;
  logic [7:0] phy_data;

  int checks = 0;
  int errors = 0;

  ulpi_if u_if ();

  assign u_if.dir  = phy_dir;
  assign u_if.nxt  = phy_nxt;
  assign u_if.data = phy_oe ? phy_data : 8'hzz;

  ulpi_link dut (
    .clk            (clk),
    .reset          (reset),
    .sys_data       (sys_data),
    .sys_data_valid (sys_data_valid),
    .sys_rx_cmd     (sys_rx_cmd),
    .sys_cmd        (sys_cmd),
    .sys_cmd_strobe (sys_cmd_strobe),
    .sys_cmd_busy   (sys_cmd_busy),
    .ulpi           (u_if)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs set afterwards are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    #1;
    checks++; if (u_if.data !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h expected 00", u_if.data); end
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sys_cmd_busy); end
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL reset_stp: got %b expected 0", u_if.stp); end
    checks++; if (sys_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sys_data_valid); end
    checks++; if (sys_rx_cmd !== 8'h00) begin errors++; $display("FAIL reset_rx_cmd: got %h expected 00", sys_rx_cmd); end
    checks++; if (sys_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", sys_data); end
  endtask

  task automatic test_rx_cmd();
    // Turnaround cycle: PHY already shows data with nxt=1, which must not be captured.
    phy_dir = 1'b1; phy_nxt = 1'b1; phy_oe = 1'b1; phy_data = 8'h77;
    tick();
    phy_nxt = 1'b0; phy_data = 8'h23;
    #1;
    checks++; if (sys_data_valid !== 1'b0) begin errors++; $display("FAIL rx_turnaround_valid: got %b expected 0", sys_data_valid); end
    checks++; if (sys_data !== 8'h00) begin errors++; $display("FAIL rx_turnaround_data: got %h expected 00", sys_data); end
    checks++; if (u_if.data !== 8'h23) begin errors++; $display("FAIL rx_bus_phy: got %h expected 23", u_if.data); end
    tick();
    phy_dir = 1'b0; phy_oe = 1'b0;
    #1;
    checks++; if (sys_rx_cmd !== 8'h23) begin errors++; $display("FAIL rx_cmd: got %h expected 23", sys_rx_cmd); end
    checks++; if (sys_data_valid !== 1'b0) begin errors++; $display("FAIL rx_cmd_valid: got %b expected 0", sys_data_valid); end
    tick();
    #1;
    checks++; if (sys_rx_cmd !== 8'h23) begin errors++; $display("FAIL rx_cmd_hold: got %h expected 23", sys_rx_cmd); end
    tick();
  endtask

  task automatic test_rx_data();
    phy_dir = 1'b1; phy_nxt = 1'b0; phy_oe = 1'b0;
    tick();
    phy_oe = 1'b1; phy_nxt = 1'b1; phy_data = 8'hA5;
    tick();
    phy_data = 8'h5A;
    #1;
    checks++; if (sys_data !== 8'hA5) begin errors++; $display("FAIL rx_data0: got %h expected a5", sys_data); end
    checks++; if (sys_data_valid !== 1'b1) begin errors++; $display("FAIL rx_valid0: got %b expected 1", sys_data_valid); end
    tick();
    phy_nxt = 1'b0; phy_data = 8'h46;
    #1;
    checks++; if (sys_data !== 8'h5A) begin errors++; $display("FAIL rx_data1: got %h expected 5a", sys_data); end
    checks++; if (sys_data_valid !== 1'b1) begin errors++; $display("FAIL rx_valid1: got %b expected 1", sys_data_valid); end
    tick();
    phy_dir = 1'b0; phy_oe = 1'b0;
    #1;
    checks++; if (sys_data_valid !== 1'b0) begin errors++; $display("FAIL rx_valid_drop: got %b expected 0", sys_data_valid); end
    checks++; if (sys_data !== 8'h5A) begin errors++; $display("FAIL rx_data_hold: got %h expected 5a", sys_data); end
    checks++; if (sys_rx_cmd !== 8'h46) begin errors++; $display("FAIL rx_cmd_after_data: got %h expected 46", sys_rx_cmd); end
    tick();
    tick();
  endtask

  task automatic test_tx();
    sys_cmd = 8'h41; sys_cmd_strobe = 1'b1;
    tick();
    sys_cmd_strobe = 1'b0; sys_cmd = 8'h99;
    #1;
    checks++; if (sys_cmd_busy !== 1'b1) begin errors++; $display("FAIL tx_busy: got %b expected 1", sys_cmd_busy); end
    checks++; if (u_if.data !== 8'h41) begin errors++; $display("FAIL tx_bus0: got %h expected 41", u_if.data); end
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL tx_stp0: got %b expected 0", u_if.stp); end
    tick();
    // A strobe while busy must be ignored.
    sys_cmd_strobe = 1'b1;
    #1;
    checks++; if (u_if.data !== 8'h41) begin errors++; $display("FAIL tx_bus1: got %h expected 41", u_if.data); end
    tick();
    sys_cmd_strobe = 1'b0; phy_nxt = 1'b1;
    #1;
    checks++; if (u_if.data !== 8'h41) begin errors++; $display("FAIL tx_bus2: got %h expected 41", u_if.data); end
    tick();
    phy_nxt = 1'b0;
    #1;
    checks++; if (u_if.stp !== 1'b1) begin errors++; $display("FAIL tx_stp: got %b expected 1", u_if.stp); end
    checks++; if (u_if.data !== 8'h00) begin errors++; $display("FAIL tx_stop_bus: got %h expected 00", u_if.data); end
    checks++; if (sys_cmd_busy !== 1'b1) begin errors++; $display("FAIL tx_stop_busy: got %b expected 1", sys_cmd_busy); end
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL tx_done_busy: got %b expected 0", sys_cmd_busy); end
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL tx_done_stp: got %b expected 0", u_if.stp); end
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL tx_ignored_strobe: got busy %b expected 0", sys_cmd_busy); end
    checks++; if (u_if.data !== 8'h00) begin errors++; $display("FAIL tx_idle_bus: got %h expected 00", u_if.data); end
  endtask

  task automatic test_abort();
    sys_cmd = 8'h41; sys_cmd_strobe = 1'b1;
    tick();
    sys_cmd_strobe = 1'b0;
    tick();
    phy_dir = 1'b1; phy_oe = 1'b0;
    #1;
    checks++; if (u_if.data === 8'h41) begin errors++; $display("FAIL abort_release: bus %h, link still driving 41", u_if.data); end
    tick();
    phy_oe = 1'b1; phy_data = 8'h80;
    #1;
    checks++; if (u_if.data !== 8'h80) begin errors++; $display("FAIL abort_bus_phy: got %h expected 80", u_if.data); end
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL abort_stp0: got %b expected 0", u_if.stp); end
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", sys_cmd_busy); end
    tick();
    phy_dir = 1'b0; phy_oe = 1'b0;
    #1;
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL abort_stp1: got %b expected 0", u_if.stp); end
    tick();
    tick();
    #1;
    checks++; if (u_if.data !== 8'h41) begin errors++; $display("FAIL abort_resend: got %h expected 41", u_if.data); end
    phy_nxt = 1'b1;
    tick();
    phy_nxt = 1'b0;
    #1;
    checks++; if (u_if.stp !== 1'b1) begin errors++; $display("FAIL abort_final_stp: got %b expected 1", u_if.stp); end
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL abort_done_busy: got %b expected 0", sys_cmd_busy); end
  endtask

  task automatic test_strobe_with_dir();
    sys_cmd = 8'h3C; sys_cmd_strobe = 1'b1; phy_dir = 1'b1;
    tick();
    sys_cmd_strobe = 1'b0;
    #1;
    checks++; if (sys_cmd_busy !== 1'b1) begin errors++; $display("FAIL sdir_busy: got %b expected 1", sys_cmd_busy); end
    checks++; if (u_if.data === 8'h3C) begin errors++; $display("FAIL sdir_release: bus %h, link driving while dir=1", u_if.data); end
    tick();
    phy_dir = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (u_if.data !== 8'h3C) begin errors++; $display("FAIL sdir_resend: got %h expected 3c", u_if.data); end
    phy_nxt = 1'b1;
    tick();
    phy_nxt = 1'b0;
    #1;
    checks++; if (u_if.stp !== 1'b1) begin errors++; $display("FAIL sdir_stp: got %b expected 1", u_if.stp); end
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL sdir_done: got %b expected 0", sys_cmd_busy); end
  endtask

  task automatic test_reset_mid_cmd();
    sys_cmd = 8'h41; sys_cmd_strobe = 1'b1;
    tick();
    sys_cmd_strobe = 1'b0;
    #1;
    checks++; if (sys_cmd_busy !== 1'b1) begin errors++; $display("FAIL rst_cmd_busy_pre: got %b expected 1", sys_cmd_busy); end
    reset = 1'b1; phy_nxt = 1'b1;
    tick();
    #1;
    checks++; if (sys_cmd_busy !== 1'b0) begin errors++; $display("FAIL rst_cmd_busy: got %b expected 0", sys_cmd_busy); end
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL rst_cmd_stp: got %b expected 0", u_if.stp); end
    checks++; if (u_if.data !== 8'h00) begin errors++; $display("FAIL rst_cmd_bus: got %h expected 00", u_if.data); end
    reset = 1'b0; phy_nxt = 1'b0;
    tick();
    #1;
    checks++; if (u_if.stp !== 1'b0) begin errors++; $display("FAIL rst_cmd_stp_after: got %b expected 0", u_if.stp); end
  endtask

  task automatic test_reset_rx();
    phy_dir = 1'b1; phy_nxt = 1'b1; phy_oe = 1'b1; phy_data = 8'hC3;
    tick();
    tick();
    reset = 1'b1;
    phy_data = 8'h3E;
    tick();
    tick();
    #1;
    checks++; if (sys_data_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", sys_data_valid); end
    checks++; if (sys_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", sys_data); end
    reset = 1'b0; phy_dir = 1'b0; phy_nxt = 1'b0; phy_oe = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; sys_cmd = 8'h00; sys_cmd_strobe = 1'b0;
    phy_dir = 1'b0; phy_nxt = 1'b0; phy_oe = 1'b0; phy_data = 8'h00;
    test_reset();
    test_rx_cmd();
    test_rx_data();
    test_tx();
    test_abort();
    test_strobe_with_dir();
    test_reset_mid_cmd();
    test_reset_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_link.md
ULPI_LINK -- requirements
Module: ulpi_link

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Port list, clock and reset first:
- clk  input  1  ULPI 60 MHz clock sourced by the PHY; all logic on its rising edge.
- reset  input  1  synchronous active-high reset.
- sys_data  output  8  last received USB data byte.
- sys_data_valid  output  1  one-cycle strobe; sys_data is new.
- sys_rx_cmd  output  8  last received RX CMD byte.
- sys_cmd  input  8  TX CMD byte to send.
- sys_cmd_strobe  input  1  one-cycle request to send sys_cmd.
- sys_cmd_busy  output  1  high while a command is in progress.
- ulpi  ulpi_if (link side)  -  bundle of the following signals.
- ulpi.dir  input  1  PHY owns the data bus when high.
- ulpi.nxt  input  1  PHY throttle / data-phase flag.
- ulpi.stp  output  1  link stop strobe.
- ulpi.data  inout  8  shared bus; tristated by the link when it is not driving.

Function
REQ-003 The block SHALL register dir_r <= ulpi.dir every cycle; turnaround = (ulpi.dir != dir_r).
REQ-004 The link SHALL drive ulpi.data only when ulpi.dir=0 and dir_r=0, gated combinationally on ulpi.dir; otherwise ulpi.data SHALL be high-Z.
REQ-005 When idle and owning the bus, the link SHALL drive 8'h00 (NOOP).
REQ-006 Receive, when ulpi.dir=1, dir_r=1 and nxt=0, at a clk edge: sys_rx_cmd SHALL take ulpi.data; it SHALL hold until the next RX CMD.
REQ-007 Receive, when ulpi.dir=1, dir_r=1 and nxt=1: sys_data SHALL take ulpi.data, and sys_data_valid SHALL be 1 for exactly that following cycle; otherwise it SHALL be 0.
REQ-008 Turnaround cycles SHALL capture nothing.
REQ-009 TX state machine, states IDLE, CMD, STOP, WAIT.
- IDLE with sys_cmd_strobe=1: latch sys_cmd, set busy=1, go to CMD.
- IDLE with strobe=0: stay, drive 00.
- CMD: drive the latched byte while the bus is owned; on nxt=1 with the bus owned, go to STOP.
- STOP: drive 8'h00 with stp=1 for exactly one cycle, then go to IDLE with busy=0.
- WAIT (abort): entered from CMD or STOP whenever ulpi.dir=1; stp=0, bus released. On dir low and dir_r low, return to CMD and resend the latched byte from the start.
REQ-010 sys_cmd_busy SHALL be 1 from the cycle after the accepted strobe through the STOP cycle inclusive.
REQ-011 A strobe while busy=1 SHALL be ignored; sys_cmd is sampled only on the accepted strobe.
REQ-012 stp SHALL never be 1 while ulpi.dir=1.
REQ-013 A strobe and a dir rise in the same cycle: accept the command, then enter WAIT.
REQ-014 All outputs except the ulpi.data tristate gating SHALL be registered.

Reset
REQ-015 While reset=1 at a clk edge:
- state becomes IDLE;
- sys_data=00, sys_data_valid=0, sys_rx_cmd=00, sys_cmd_busy=0, ulpi.stp=0;
- the link drive value becomes 00;
- dir_r becomes 0.
REQ-016 Reset mid-command SHALL abandon the command without asserting stp.
REQ-017 Receive capture SHALL be disabled while reset=1.

Verification
REQ-018 Idle: reset released, dir=0 -> ulpi.data=00 driven by the link, busy=0, stp=0.
REQ-019 RX CMD: PHY raises dir for 1 turnaround cycle, then drives 8'h23 with nxt=0 for 1 cycle, then drops dir -> sys_rx_cmd=23; sys_data_valid stays 0; link stays off the bus during turnaround and while dir=1.
REQ-020 RX data: dir=1 and nxt=1 with data A5 then 5A on consecutive cycles -> sys_data A5 then 5A, each with a one-cycle valid.
REQ-021 TX: strobe with sys_cmd=8'h41; PHY holds nxt=0 for 2 cycles, then nxt=1 -> 41 is driven until nxt, then 1 cycle of data 00 with stp=1; busy falls after the stp cycle.
REQ-022 Abort: during CMD the PHY raises dir for 3 cycles -> bus released, no stp; after dir low plus 1 turnaround cycle, 41 is driven again.
REQ-023 Reset asserted in CMD -> next cycle busy=0, stp=0, link drives 00.
